// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encodings, bus defaults and memory command type for the data cache
package dcache_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_REFILL = 3'd2;
    localparam logic [2:0] S_UNC    = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;
    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FC00;
    localparam logic [3:0] STRB_LINE = 4'hF;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_cmd_t;
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: memory-side port B bus between the data cache (master) and memory/MMIO (slave)
interface dcache_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: one-word-per-line storage with combinational read and a byte-strobed write port
module dcache_array #(
    parameter int LINES = 64,
    localparam int IDX = $clog2(LINES),
    localparam int TW = 30 - IDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDX-1:0]  idx,
    output logic            line_valid,
    output logic            line_dirty,
    output logic [TW-1:0]   line_tag,
    output logic [31:0]     line_data,
    input  logic            we,
    input  logic [TW-1:0]   wtag,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wdirty
);
    logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TW-1:0]    tag_q [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      word_d;

    assign line_valid = valid_q[idx];
    assign line_dirty = dirty_q[idx];
    assign line_tag   = tag_q[idx];
    assign line_data  = data_q[idx];

    // Next valid/dirty vectors and the strobe-merged word for the addressed line
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        word_d  = data_q[idx];
        if (we) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = wdirty;
        end
        for (int i = 0; i < 4; i++)
            if (wstrb[i]) word_d[8*i +: 8] = wdata[8*i +: 8];
    end

    // Valid and dirty bits are the only state cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage, written on refill completion or store hit
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= wtag;
            data_q[idx] <= word_d;
        end
    end
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-back data cache with uncached MMIO bypass and pipeline stall
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    output logic        dstall,
    dcache_if.master    mem
);
    localparam int IDX = $clog2(LINES);
    localparam int TW = 30 - IDX;

    logic [2:0]     state_q, state_d;
    logic [31:0]    resp_q, resp_d;
    logic [IDX-1:0] idx;
    logic [TW-1:0]  tag;
    logic           uncached, hit;
    logic           line_valid, line_dirty;
    logic [TW-1:0]  line_tag;
    logic [31:0]    line_data;
    logic           arr_we, arr_dirty;
    logic [31:0]    arr_wdata;
    logic [3:0]     arr_wstrb;
    mem_cmd_t       cmd;

    assign idx      = req_addr[IDX+1:2];
    assign tag      = req_addr[31:IDX+2];
    assign uncached = req_addr >= MMIO_BASE;
    assign hit      = line_valid && line_tag == tag;

    assign mem.mem_req   = cmd.req;
    assign mem.mem_we    = cmd.we;
    assign mem.mem_addr  = cmd.addr;
    assign mem.mem_wdata = cmd.wdata;
    assign mem.mem_wstrb = cmd.wstrb;

    dcache_array #(.LINES(LINES)) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .line_data  (line_data),
        .we         (arr_we),
        .wtag       (tag),
        .wdata      (arr_wdata),
        .wstrb      (arr_wstrb),
        .wdirty     (arr_dirty)
    );

    // FSM: hit service, victim write-back, refill, and single-shot uncached transactions
    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        cmd       = '0;
        dstall    = 1'b0;
        rdata     = '0;
        arr_we    = 1'b0;
        arr_wdata = req_wdata;
        arr_wstrb = req_wstrb;
        arr_dirty = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (uncached) begin
                        dstall  = 1'b1;
                        state_d = S_UNC;
                    end else if (hit) begin
                        arr_we = req_we;
                        rdata  = req_we ? '0 : line_data;
                    end else begin
                        dstall  = 1'b1;
                        state_d = (line_valid && line_dirty) ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                dstall = 1'b1;
                cmd    = '{1'b1, 1'b1, {line_tag, idx, 2'b00}, line_data, STRB_LINE};
                if (mem.mem_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                dstall = 1'b1;
                cmd    = '{1'b1, 1'b0, word_addr(req_addr), 32'h0, STRB_LINE};
                if (mem.mem_ready) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem.mem_rdata;
                    arr_wstrb = STRB_LINE;
                    arr_dirty = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_UNC: begin
                dstall = 1'b1;
                cmd    = '{1'b1, req_we, word_addr(req_addr), req_wdata, req_wstrb};
                if (mem.mem_ready) begin
                    resp_d  = mem.mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rdata   = resp_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured uncached read word; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: table-driven, scoreboarded check of the data cache against a behavioural memory
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] rdata;
    logic        dstall;

    dcache_if m();

    dcache #(.LINES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rdata     (rdata),
        .dstall    (dstall),
        .mem       (m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tx_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
        int          stalls;
        int          ntx;
        logic        t_we;
        logic [31:0] t_addr;
        logic [31:0] t_wdata;
        logic [3:0]  t_strb;
    } vec_t;

    tx_t         log_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mem_model [logic [31:0]];
    vec_t        vt[$];
    int          lat = 2;
    int          cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] w;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : pat(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp, input int stalls, input int ntx,
                       input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                       input logic [3:0] t_strb);
        vt.push_back('{we, a, wd, st, exp, stalls, ntx, t_we, t_addr, t_wdata, t_strb});
    endtask

    // Memory responder: completes each transaction after lat cycles of mem_req
    initial begin
        m.mem_ready = 1'b0;
        m.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || !m.mem_req) begin
                cnt = 0;
                m.mem_ready = 1'b0;
            end else begin
                cnt = m.mem_ready ? 1 : cnt + 1;
                m.mem_ready = cnt >= lat;
                if (m.mem_ready) begin
                    log_q.push_back('{m.mem_we, m.mem_addr, m.mem_wdata, m.mem_wstrb});
                    if (m.mem_we) begin
                        w = mem_rd(m.mem_addr);
                        for (int i = 0; i < 4; i++)
                            if (m.mem_wstrb[i]) w[8*i +: 8] = m.mem_wdata[8*i +: 8];
                        mem_model[m.mem_addr] = w;
                    end else begin
                        m.mem_rdata = mem_rd(m.mem_addr);
                    end
                end
            end
        end
    end

    // Load-data monitor: pops the scoreboard whenever a load completes
    initial forever begin
        @(negedge clk);
        #2;
        if (rst && req_valid && !req_we && !dstall) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_load: got %h want no load output", rdata);
            end else begin
                check("load_rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          input logic [31:0] exp, output int stalls);
        bit done;
        done = 1'b0;
        @(negedge clk);
        log_q.delete();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = st;
        if (!we) exp_q.push_back(exp);
        stalls = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            #2;
            if (!dstall) done = 1'b1;
            else begin
                stalls++;
                @(negedge clk);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL access_timeout: addr %h still stalled, want completion within 60 cycles", a);
        end
    endtask

    initial begin
        int  st;
        bit  seen;
        add(0, 32'h100, 0, 0, 32'hDEADBEEF, 3, 1, 0, 32'h100, 0, 0);
        add(0, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        add(1, 32'h100, 32'h0000_00AA, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h100, 0, 0, 32'hDEADBEAA, 0, 0, 0, 0, 0, 0);
        add(0, 32'h200, 0, 0, pat(32'h200), 5, 2, 1, 32'h100, 32'hDEADBEAA, 4'hF);
        add(1, 32'hFFFF_FC10, 32'h5, 4'hF, 0, 3, 1, 1, 32'hFFFF_FC10, 32'h5, 4'hF);
        add(0, 32'hFFFF_FC10, 0, 0, 32'h5, 3, 1, 0, 32'hFFFF_FC10, 0, 0);
        add(0, 32'h200, 0, 0, pat(32'h200), 0, 0, 0, 0, 0, 0);
        add(0, 32'h110, 0, 0, pat(32'h110), 3, 1, 0, 32'h110, 0, 0);
        add(0, 32'h104, 0, 0, pat(32'h104), 3, 1, 0, 32'h104, 0, 0);
        add(0, 32'h108, 0, 0, pat(32'h108), 3, 1, 0, 32'h108, 0, 0);
        add(1, 32'h104, 32'h1122_3344, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h108, 0, 0, pat(32'h108), 0, 0, 0, 0, 0, 0);
        add(1, 32'h110, 32'h0000_7700, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h104, 0, 0, 32'h1122_3344, 0, 0, 0, 0, 0, 0);
        add(0, 32'h110, 0, 0, 32'h0110_77EF, 0, 0, 0, 0, 0, 0);
        add(0, 32'h200, 0, 0, pat(32'h200), 0, 0, 0, 0, 0, 0);
        add(0, 32'h0FC, 0, 0, pat(32'h0FC), 3, 1, 0, 32'h0FC, 0, 0);
        add(0, 32'h100, 0, 0, 32'hDEADBEAA, 3, 1, 0, 32'h100, 0, 0);
        add(1, 32'h0FC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        add(0, 32'h1FC, 0, 0, pat(32'h1FC), 5, 2, 1, 32'h0FC, 32'hCAFE_F00D, 4'hF);
        add(0, 32'h0FC, 0, 0, 32'hCAFE_F00D, 3, 1, 0, 32'h0FC, 0, 0);
        mem_model[32'h100] = 32'hDEADBEEF;

        #2;
        check("rst_dstall", 32'(dstall), 0);
        check("rst_mem_req", 32'(m.mem_req), 0);
        check("rst_mem_we", 32'(m.mem_we), 0);
        check("rst_mem_addr", m.mem_addr, 0);
        check("rst_mem_wdata", m.mem_wdata, 0);
        check("rst_mem_wstrb", 32'(m.mem_wstrb), 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("idle_dstall", 32'(dstall), 0);
        check("idle_mem_req", 32'(m.mem_req), 0);

        for (int i = 0; i < vt.size(); i++) begin
            access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].exp, st);
            check($sformatf("v%0d_stalls", i), st, vt[i].stalls);
            check($sformatf("v%0d_ntx", i), log_q.size(), vt[i].ntx);
            if (vt[i].ntx > 0 && log_q.size() > 0) begin
                check($sformatf("v%0d_tx_we", i), 32'(log_q[0].we), 32'(vt[i].t_we));
                check($sformatf("v%0d_tx_addr", i), log_q[0].addr, vt[i].t_addr);
                if (vt[i].t_we) begin
                    check($sformatf("v%0d_tx_wdata", i), log_q[0].wdata, vt[i].t_wdata);
                    check($sformatf("v%0d_tx_wstrb", i), 32'(log_q[0].wstrb), 32'(vt[i].t_strb));
                end
                if (!vt[i].we) begin
                    check($sformatf("v%0d_fill_we", i), 32'(log_q[log_q.size()-1].we), 0);
                    check($sformatf("v%0d_fill_addr", i), log_q[log_q.size()-1].addr, {vt[i].addr[31:2], 2'b00});
                end
            end
        end
        @(negedge clk);
        req_valid = 1'b0;

        lat = 10;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h800;
        for (int c = 0; c < 20 && !seen; c++) begin
            #2;
            if (m.mem_req) seen = 1'b1;
            else @(negedge clk);
        end
        check("refill_req_seen", 32'(seen), 1);
        #1;
        rst = 1'b0;
        #1;
        check("abort_mem_req", 32'(m.mem_req), 0);
        check("abort_mem_we", 32'(m.mem_we), 0);
        check("abort_mem_addr", m.mem_addr, 0);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        lat = 2;
        access(0, 32'h800, 0, 0, pat(32'h800), st);
        check("rerun_stalls", st, 3);
        check("rerun_ntx", log_q.size(), 1);
        access(0, 32'h104, 0, 0, pat(32'h104), st);
        check("post_rst_miss_stalls", st, 3);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
